// File: rtl/uart_program_loader.sv
// uart_program_loader: receives a program image over 8N1 UART and writes it
// into the core's BRAM as little-endian 32-bit words. The image starts with a
// 4-byte little-endian word count N, followed by N words. When the last word
// is written, the block sends one ACK byte on txd and then raises the sticky
// done flag that releases the core.
module uart_program_loader #(
    parameter int          CLK_PER_HALF_BIT = 5208,
    parameter int          ADDR_W           = 20,
    parameter logic [7:0]  ACK_BYTE         = 8'hAA
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    output logic              txd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              frame_err
);

    localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
    localparam int CW      = $clog2(BIT_CYC + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {L_LEN, L_DATA, L_ACK, L_DONE}    ld_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

    // ------------------------------------------------------------------
    // rxd synchronizer
    // ------------------------------------------------------------------
    logic rx_meta, rx_sync;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the old
            // value of its neighbour, which is what makes this a real 2-stage
            // chain instead of a single wire.
            rx_meta <= rxd;
            rx_sync <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    rx_state_t       rx_state, rx_next;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            rx_valid;
    logic            rx_half_tick, rx_bit_tick;

    assign rx_half_tick = (rx_cnt == HALF_LAST);
    assign rx_bit_tick  = (rx_cnt == BIT_LAST);

    // Receiver next-state: centre on the start bit, then sample each bit mid-cell.
    always_comb begin
        // NOTE: assigning a default first guarantees every path writes
        // rx_next, so no latch is inferred for the unlisted cases.
        rx_next = rx_state;
        unique case (rx_state)
            R_IDLE:  if (!rx_sync) rx_next = R_START;
            R_START: if (rx_half_tick) rx_next = rx_sync ? R_IDLE : R_DATA;
            R_DATA:  if (rx_bit_tick && rx_bit == 3'd7) rx_next = R_STOP;
            R_STOP:  if (rx_bit_tick) rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase
    end

    // Receiver state, bit timer, shift register, byte strobe and framing flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state  <= R_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_state <= rx_next;
            rx_valid <= 1'b0;
            // Timer restarts on every state change and at every bit boundary.
            if (rx_state == R_IDLE || rx_next != rx_state || rx_bit_tick)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 1'b1;

            if (rx_state == R_START)
                rx_bit <= '0;

            if (rx_state == R_DATA && rx_bit_tick) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                rx_bit   <= rx_bit + 1'b1;
            end

            if (rx_state == R_STOP && rx_bit_tick) begin
                if (rx_sync) rx_valid  <= 1'b1;
                else         frame_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Loader: length header, word assembly, BRAM writes, ACK handshake
    // ------------------------------------------------------------------
    ld_state_t   l_state, l_next;
    logic [1:0]  l_cnt;
    logic [31:0] len, len_next, word, word_next, index;
    logic        ack_started;
    logic        tx_start, tx_done;

    assign len_next  = {rx_shift, len[31:8]};
    assign word_next = {rx_shift, word[31:8]};
    assign tx_start  = (l_state == L_ACK) && !ack_started;
    assign busy      = (l_state != L_DONE);
    assign done      = (l_state == L_DONE);

    // Loader next-state: header -> words -> ACK -> done.
    always_comb begin
        l_next = l_state;
        unique case (l_state)
            L_LEN:   if (rx_valid && l_cnt == 2'd3)
                         l_next = (len_next == 32'd0) ? L_ACK : L_DATA;
            L_DATA:  if (rx_valid && l_cnt == 2'd3 && index + 32'd1 == len)
                         l_next = L_ACK;
            L_ACK:   if (tx_done) l_next = L_DONE;
            L_DONE:  l_next = L_DONE;
            default: l_next = L_LEN;
        endcase
    end

    // Loader datapath: byte assembly and the registered one-cycle write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_state     <= L_LEN;
            l_cnt       <= '0;
            len         <= '0;
            word        <= '0;
            index       <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            ack_started <= 1'b0;
        end else begin
            l_state <= l_next;
            mem_we  <= 1'b0;
            if (tx_start) ack_started <= 1'b1;
            if (rx_valid) begin
                unique case (l_state)
                    L_LEN: begin
                        len   <= len_next;
                        l_cnt <= l_cnt + 1'b1;
                        index <= '0;
                    end
                    L_DATA: begin
                        word  <= word_next;
                        l_cnt <= l_cnt + 1'b1;
                        if (l_cnt == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= word_next;
                            mem_addr  <= index[ADDR_W-1:0];
                            index     <= index + 32'd1;
                        end
                    end
                    default: ;  // bytes after the image are ignored
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // UART transmitter (ACK byte only)
    // ------------------------------------------------------------------
    tx_state_t     tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_bit_tick;

    assign tx_bit_tick = (tx_cnt == BIT_LAST);
    assign tx_done     = (tx_state == T_STOP) && tx_bit_tick;

    // Transmitter next-state: start bit, 8 data bits, stop bit.
    always_comb begin
        tx_next = tx_state;
        unique case (tx_state)
            T_IDLE:  if (tx_start) tx_next = T_START;
            T_START: if (tx_bit_tick) tx_next = T_DATA;
            T_DATA:  if (tx_bit_tick && tx_bit == 3'd7) tx_next = T_STOP;
            T_STOP:  if (tx_bit_tick) tx_next = T_IDLE;
            default: tx_next = T_IDLE;
        endcase
    end

    // Transmitter state, bit timer and registered (glitch-free) txd.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= T_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_next;
            if (tx_state == T_IDLE || tx_bit_tick)
                tx_cnt <= '0;
            else
                tx_cnt <= tx_cnt + 1'b1;

            unique case (tx_state)
                T_IDLE: if (tx_start) begin
                    txd      <= 1'b0;
                    tx_shift <= ACK_BYTE;
                end
                T_START: if (tx_bit_tick) begin
                    txd      <= tx_shift[0];
                    tx_shift <= {1'b0, tx_shift[7:1]};
                    tx_bit   <= '0;
                end
                T_DATA: if (tx_bit_tick) begin
                    tx_bit <= tx_bit + 1'b1;
                    if (tx_bit == 3'd7) begin
                        txd <= 1'b1;
                    end else begin
                        txd      <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                    end
                end
                T_STOP:  txd <= 1'b1;
                default: txd <= 1'b1;
            endcase
        end
    end

endmodule
